// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and request legality check for the load/store unit.
// Pure definitions: no latency, no backpressure.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Misaligned or unsupported width; unsigned widths exist only for loads.
  function automatic logic req_bad(input logic store, input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lo[0];
      F3_W:    bad = (lo != 2'b00);
      F3_BU:   bad = store;
      F3_HU:   bad = store | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract with sign/zero extension for loads, and lane merge for sub-word stores.
// Purely combinational, zero latency; no backpressure.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] merge,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = rdata[{off, 3'b000} +: 8];
    lane_h    = rdata[{off[1], 4'b0000} +: 16];
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, lane_b};
      F3_H:    load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, lane_h};
      default: load_data = rdata;
    endcase
  end

  // Only the addressed lane is replaced; the rest comes from the word read in ACCESS.
  always_comb begin
    store_data = merge;
    case (funct3[1:0])
      2'b00:   store_data[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one access at a time, read-modify-write for SB/SH; LSU_BOUNDS_CHECK_EN faults high address bits.
// Latency accept->resp_valid: fault 1, load/SW 2, SB/SH 3 cycles.
// Backpressure: req_ready only in IDLE; response held in RESP until resp_ready.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 6,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_load,
  output logic              mem_store,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  state_t              state_q, state_d;
  logic                store_q;
  logic [2:0]          f3_q;
  logic [MEM_AW+1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [XLEN-1:0]     merge_q;
  logic [XLEN-1:0]     rdata_q;
  logic                fault_q;
  logic                accept;
  logic                oob;
  logic                req_fault;
  logic [XLEN-1:0]     load_ext;
  logic [XLEN-1:0]     merged;
  logic                unused_addr;

  assign accept      = req_valid & req_ready;
  assign unused_addr = ^req_addr[XLEN-1:MEM_AW+2];

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob = |req_addr[XLEN-1:MEM_AW+2];
`else
  assign oob = 1'b0;
`endif

  assign req_fault = oob | req_bad(req_store, req_funct3, req_addr[1:0]);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (f3_q),
    .off        (addr_q[1:0]),
    .rdata      (mem_rdata),
    .merge      (merge_q),
    .wdata      (wdata_q),
    .load_data  (load_ext),
    .store_data (merged)
  );

  // Memory strobes depend on state_q only, so an async reset kills them at once.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_load   = 1'b0;
    mem_store  = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_fault ? RESP : ACCESS;
      end
      ACCESS: begin
        if (!store_q) begin
          mem_load = 1'b1;
          state_d  = RESP;
        end else if (f3_q == F3_W) begin
          mem_store = 1'b1;
          mem_wdata = wdata_q;
          state_d   = RESP;
        end else begin
          mem_load = 1'b1;
          state_d  = MERGE;
        end
      end
      MERGE: begin
        mem_store = 1'b1;
        mem_wdata = merged;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[MEM_AW+1:0];
        wdata_q <= req_wdata;
        fault_q <= req_fault;
        rdata_q <= '0;
      end
      if (state_q == ACCESS && !store_q) rdata_q <= load_ext;
      if (state_q == ACCESS && store_q)  merge_q <= mem_rdata;
    end
  end

  assign mem_addr   = addr_q[MEM_AW+1:2];
  assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign resp_fault = (state_q == RESP) & fault_q;

endmodule
